// File: rtl/mem_pkg.sv
// Shared memory-port encodings and DMA state constants, used by the copy engine
// and the data memory.
package mem_pkg;

   localparam logic [1:0] MEM_IDLE  = 2'b00;
   localparam logic [1:0] MEM_WRITE = 2'b01;
   localparam logic [1:0] MEM_READ  = 2'b10;

   typedef logic [1:0] dma_state_t;

   localparam dma_state_t DMA_IDLE  = 2'd0;
   localparam dma_state_t DMA_READ  = 2'd1;
   localparam dma_state_t DMA_WRITE = 2'd2;
   localparam dma_state_t DMA_DONE  = 2'd3;

endpackage

// File: rtl/mem_copy_dma.sv
// Bus-master block copy engine: one read cycle then one write cycle per word.
// Optional block-fill mode is enabled by defining MEM_COPY_FILL_EN.
module mem_copy_dma
   import mem_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 13
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [LEN_W-1:0]  length,
`ifdef MEM_COPY_FILL_EN
   input  logic              fill,
   input  logic [DATA_W-1:0] fill_value,
`endif
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data_in,
   output logic [1:0]        mem_inst,
   input  logic [DATA_W-1:0] mem_data_out
);

   dma_state_t        state;
   logic [ADDR_W-1:0] src_r;
   logic [ADDR_W-1:0] dst_r;
   logic [LEN_W-1:0]  len_r;
   logic [LEN_W-1:0]  idx;
   logic [DATA_W-1:0] hold;
   logic              start_fill;
   logic              fill_mode;
   logic [DATA_W-1:0] write_data;
   logic              last_word;

`ifdef MEM_COPY_FILL_EN
   logic              fill_r;
   logic [DATA_W-1:0] fill_value_r;

   always_ff @(posedge clk) begin
      if (reset) begin
         fill_r       <= 1'b0;
         fill_value_r <= '0;
      end else if (state == DMA_IDLE && start) begin
         fill_r       <= fill;
         fill_value_r <= fill_value;
      end
   end

   assign start_fill = fill;
   assign fill_mode  = fill_r;
   assign write_data = fill_r ? fill_value_r : hold;
`else
   assign start_fill = 1'b0;
   assign fill_mode  = 1'b0;
   assign write_data = hold;
`endif

   assign last_word = ((idx + LEN_W'(1)) == len_r);

   // Fill mode bypasses READ entirely, so each word costs a single WRITE cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= DMA_IDLE;
         src_r <= '0;
         dst_r <= '0;
         len_r <= '0;
         idx   <= '0;
         hold  <= '0;
      end else begin
         case (state)
            DMA_IDLE: begin
               if (start) begin
                  if (length != '0) begin
                     src_r <= src_addr;
                     dst_r <= dst_addr;
                     len_r <= length;
                     idx   <= '0;
                     state <= start_fill ? DMA_WRITE : DMA_READ;
                  end else begin
                     state <= DMA_DONE;
                  end
               end
            end
            DMA_READ: begin
               hold  <= mem_data_out;
               state <= DMA_WRITE;
            end
            DMA_WRITE: begin
               idx <= idx + LEN_W'(1);
               if (last_word) begin
                  state <= DMA_DONE;
               end else begin
                  state <= fill_mode ? DMA_WRITE : DMA_READ;
               end
            end
            default: begin
               state <= DMA_IDLE;
            end
         endcase
      end
   end

   // Memory port is decoded purely from registered state, never from start.
   always_comb begin
      busy        = 1'b0;
      done        = 1'b0;
      mem_inst    = MEM_IDLE;
      mem_address = '0;
      mem_data_in = '0;
      case (state)
         DMA_READ: begin
            busy        = 1'b1;
            mem_inst    = MEM_READ;
            mem_address = src_r + ADDR_W'(idx);
         end
         DMA_WRITE: begin
            busy        = 1'b1;
            mem_inst    = MEM_WRITE;
            mem_address = dst_r + ADDR_W'(idx);
            mem_data_in = write_data;
         end
         DMA_DONE: begin
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Scoreboard testbench for mem_copy_dma with a 4096-word combinational memory.
// Define MEM_COPY_FILL_EN to also exercise the fill mode.
module tb_mem_copy_dma;
   import mem_pkg::*;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] srcAddr;
   logic [31:0] dstAddr;
   logic [12:0] length;
   logic        fill;
   logic [31:0] fillValue;
   logic        busy;
   logic        done;
   logic [31:0] memAddress;
   logic [31:0] memDataIn;
   logic [1:0]  memInst;
   logic [31:0] memDataOut;

   logic [31:0] mem  [4096];
   logic [31:0] gold [4096];
   logic        loadEn;
   logic [11:0] loadAddr;
   logic [31:0] loadData;
   logic        monitorOn;

   logic [31:0] readQ[$];
   logic [63:0] writeQ[$];

   int checks;
   int failures;

   mem_copy_dma #(.ADDR_W(32), .DATA_W(32), .LEN_W(13)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .src_addr(srcAddr),
      .dst_addr(dstAddr),
      .length(length),
`ifdef MEM_COPY_FILL_EN
      .fill(fill),
      .fill_value(fillValue),
`endif
      .busy(busy),
      .done(done),
      .mem_address(memAddress),
      .mem_data_in(memDataIn),
      .mem_inst(memInst),
      .mem_data_out(memDataOut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Data memory: combinational read, commits writes on the rising edge.
   assign memDataOut = mem[memAddress[11:0]];

   always @(posedge clk) begin
      if (loadEn) begin
         mem[loadAddr] <= loadData;
      end else if (memInst == MEM_WRITE) begin
         mem[memAddress[11:0]] <= memDataIn;
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   // Monitor: every memory access the DUT presents must match the next queued expectation.
   always @(negedge clk) begin
      if (monitorOn) begin
         if (memInst != MEM_WRITE) checkOutput("dataInOutsideWrite", memDataIn, 0);
         case (memInst)
            MEM_IDLE: checkOutput("addrWhenIdle", memAddress, 0);
            MEM_READ: begin
               if (readQ.size() == 0) checkOutput("spuriousRead", readQ.size(), 1);
               else checkOutput("readAddr", memAddress, readQ.pop_front());
            end
            MEM_WRITE: begin
               if (writeQ.size() == 0) checkOutput("spuriousWrite", writeQ.size(), 1);
               else checkOutput("writeAddrData", {memAddress, memDataIn}, writeQ.pop_front());
            end
            default: checkOutput("illegalMemInst", memInst, MEM_IDLE);
         endcase
      end
   end

   function automatic int countMismatches();
      int n = 0;
      for (int i = 0; i < 4096; i++) if (mem[i] !== gold[i]) n++;
      return n;
   endfunction

   // Reference model: forward sequential word copy on the golden image, low 12 address bits decoded.
   task automatic modelCopy(input logic [31:0] s, input logic [31:0] d, input int n, input logic f, input logic [31:0] fv);
      logic [31:0] sa, da, wd;
      for (int k = 0; k < n; k++) begin
         sa = s + k;
         da = d + k;
         if (f) begin
            wd = fv;
         end else begin
            readQ.push_back(sa);
            wd = gold[sa[11:0]];
         end
         writeQ.push_back({da, wd});
         gold[da[11:0]] = wd;
      end
   endtask

   task automatic checkIdleAfter(input int cycles);
      int seen = 0;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         seen += int'(done) + int'(busy);
      end
      checkOutput("idleAfterDone", seen, 0);
      checkOutput("queuesDrained", readQ.size() + writeQ.size(), 0);
      checkOutput("memImage", countMismatches(), 0);
   endtask

   task automatic applyStimulus(input logic [31:0] s, input logic [31:0] d, input int n,
                                input logic f, input logic [31:0] fv, input int injectCycle);
      int busyCycles = 0;
      int doneAt = -1;
      int expBusy = f ? n : 2 * n;
      modelCopy(s, d, n, f, fv);
      @(negedge clk);
      start = 1'b1; srcAddr = s; dstAddr = d; length = 13'(n); fill = f; fillValue = fv;
      @(posedge clk);
      #1;
      start = 1'b0; srcAddr = $urandom; dstAddr = $urandom; length = 13'($urandom_range(1, 8));
      fillValue = $urandom;
      for (int cyc = 0; cyc < expBusy + 8 && doneAt < 0; cyc++) begin
         @(negedge clk);
         if (cyc == injectCycle) begin
            start = 1'b1; srcAddr = 32'd50; dstAddr = 32'd900; length = 13'd3;
         end else begin
            start = 1'b0;
         end
         if (done) doneAt = cyc;
         else if (busy) busyCycles++;
      end
      start = 1'b0;
      checkOutput("doneCycle", doneAt, expBusy);
      checkOutput("busyCycles", busyCycles, expBusy);
      checkIdleAfter(3);
   endtask

   // Reset lands during the second word's WRITE cycle, so two words reach memory.
   task automatic applyResetAbort(input logic [31:0] s, input logic [31:0] d);
      modelCopy(s, d, 2, 1'b0, 32'h0);
      @(negedge clk);
      start = 1'b1; srcAddr = s; dstAddr = d; length = 13'd4; fill = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("inWriteBeforeReset", memInst, MEM_WRITE);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("resetBusy", busy, 0);
      checkOutput("resetDone", done, 0);
      checkOutput("resetMemInst", memInst, MEM_IDLE);
      checkOutput("resetAddr", memAddress, 0);
      checkOutput("resetDataIn", memDataIn, 0);
      reset = 1'b0;
      checkIdleAfter(4);
   endtask

   initial begin
      checks = 0; failures = 0; monitorOn = 1'b0;
      reset = 1'b1; start = 1'b0; srcAddr = '0; dstAddr = '0; length = '0;
      fill = 1'b0; fillValue = '0; loadEn = 1'b0; loadAddr = '0; loadData = '0;

      for (int i = 0; i < 4096; i++) begin
         @(negedge clk);
         loadEn = 1'b1;
         loadAddr = 12'(i);
         loadData = (i >= 4 && i <= 7) ? 32'hA0 + 32'(i - 4) : $urandom;
         gold[i] = loadData;
      end
      @(negedge clk);
      loadEn = 1'b0;
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstDone", done, 0);
      checkOutput("rstMemInst", memInst, MEM_IDLE);
      checkOutput("rstAddr", memAddress, 0);
      checkOutput("rstDataIn", memDataIn, 0);
      reset = 1'b0;
      monitorOn = 1'b1;

      $display("[TB] basic copy 4..7 -> 100..103");
      applyStimulus(32'd4, 32'd100, 4, 1'b0, 32'h0, -1);
      for (int k = 0; k < 4; k++) checkOutput("copyA", mem[100 + k], 32'hA0 + 32'(k));

      $display("[TB] zero length");
      applyStimulus(32'd300, 32'd400, 0, 1'b0, 32'h0, -1);

      $display("[TB] wrap at 4096-word boundary");
      applyStimulus(32'd4094, 32'd10, 4, 1'b0, 32'h0, -1);

      $display("[TB] start ignored while busy");
      applyStimulus(32'd20, 32'd300, 5, 1'b0, 32'h0, 3);

      $display("[TB] reset mid-transfer");
      applyResetAbort(32'd600, 32'd700);

      $display("[TB] overlapping forward copy");
      applyStimulus(32'd1000, 32'd1002, 6, 1'b0, 32'h0, -1);

      $display("[TB] randomized copies");
      for (int t = 0; t < 8; t++) begin
         applyStimulus($urandom, $urandom, $urandom_range(1, 16), 1'b0, 32'h0, -1);
      end

      $display("[TB] maximum length");
      applyStimulus(32'd0, 32'd1, 4096, 1'b0, 32'h0, -1);

`ifdef MEM_COPY_FILL_EN
      $display("[TB] fill mode");
      applyStimulus(32'd0, 32'd200, 3, 1'b1, 32'hDEADBEEF, -1);
      for (int k = 0; k < 3; k++) checkOutput("fillWord", mem[200 + k], 32'hDEADBEEF);
      applyStimulus($urandom, $urandom, $urandom_range(1, 10), 1'b1, $urandom, -1);
      applyStimulus(32'd5, 32'd800, 4, 1'b0, 32'h0, -1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
